// File: rtl/chip8_sound_delay_timers.sv
// rtl/chip8_sound_delay_timers.sv - CHIP-8 delay/sound timer registers and buzzer tone generator
module chip8_sound_delay_timers #(
  parameter int CLOCK_HZ    = 12000000,
  parameter int TONE_HZ     = 440,
  parameter int HALF_PERIOD = CLOCK_HZ / (2 * TONE_HZ)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timer_60hz_tick,
  input  logic       dt_we,
  input  logic       st_we,
  input  logic [7:0] wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       sound_active,
  output logic       buzzer
);

  localparam int          HP      = (HALF_PERIOD < 1) ? 1 : HALF_PERIOD;
  localparam logic [31:0] HP_LAST = 32'(HP - 1);

  typedef enum logic {IDLE, TONE} tone_state_t;

  tone_state_t state;
  logic [7:0]  dt, st, dt_next, st_next;
  logic [31:0] tone_cnt;
  logic        buzzer_q;

  // Write beats tick per register; ticks saturate at zero.
  always_comb begin
    dt_next = dt;
    st_next = st;
    if (dt_we)
      dt_next = wdata;
    else if (timer_60hz_tick && dt != 8'd0)
      dt_next = dt - 8'd1;
    if (st_we)
      st_next = wdata;
    else if (timer_60hz_tick && st != 8'd0)
      st_next = st - 8'd1;
  end

  // Tone follows st_next so the buzzer drops on the same edge ST reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      dt       <= 8'd0;
      st       <= 8'd0;
      state    <= IDLE;
      tone_cnt <= 32'd0;
      buzzer_q <= 1'b0;
    end else begin
      dt <= dt_next;
      st <= st_next;
      case (state)
        IDLE: begin
          tone_cnt <= 32'd0;
          buzzer_q <= 1'b0;
          if (st_next != 8'd0)
            state <= TONE;
        end
        TONE: begin
          if (st_next == 8'd0) begin
            state    <= IDLE;
            tone_cnt <= 32'd0;
            buzzer_q <= 1'b0;
          end else if (tone_cnt == HP_LAST) begin
            tone_cnt <= 32'd0;
            buzzer_q <= ~buzzer_q;
          end else begin
            tone_cnt <= tone_cnt + 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tone_cnt <= 32'd0;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign dt_value     = dt;
  assign st_value     = st;
  assign sound_active = (st != 8'd0);
  assign buzzer       = buzzer_q;

endmodule

// File: tb/tb_chip8_sound_delay_timers.sv
// tb/tb_chip8_sound_delay_timers.sv - self-checking bench for chip8_sound_delay_timers
module tb_chip8_sound_delay_timers;

  localparam int HP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       timer_60hz_tick = 1'b0;
  logic       dt_we = 1'b0;
  logic       st_we = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] dt_value, st_value;
  logic       sound_active, buzzer;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: register values plus clocks elapsed since the tone began (-1 = silent).
  int m_dt = 0;
  int m_st = 0;
  int m_k  = -1;

  chip8_sound_delay_timers #(.HALF_PERIOD(HP)) dut (
    .clk(clk), .reset(reset), .timer_60hz_tick(timer_60hz_tick),
    .dt_we(dt_we), .st_we(st_we), .wdata(wdata),
    .dt_value(dt_value), .st_value(st_value),
    .sound_active(sound_active), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model_out();
    logic bz;
    bz = (m_k >= 0) && (((m_k / HP) % 2) == 1);
    return {8'(m_dt), 8'(m_st), (m_st != 0), bz};
  endfunction

  function automatic logic [17:0] dut_out();
    return {dt_value, st_value, sound_active, buzzer};
  endfunction

  task automatic step(input logic r, input logic t, input logic dw, input logic sw,
                      input logic [7:0] wd);
    int nd, ns;
    reset = r; timer_60hz_tick = t; dt_we = dw; st_we = sw; wdata = wd;
    @(posedge clk);
    if (r) begin
      m_dt = 0; m_st = 0; m_k = -1;
    end else begin
      nd = dw ? int'(wd) : ((t && m_dt > 0) ? m_dt - 1 : m_dt);
      ns = sw ? int'(wd) : ((t && m_st > 0) ? m_st - 1 : m_st);
      if (ns == 0) m_k = -1;
      else if (m_st == 0) m_k = 0;
      else m_k = m_k + 1;
      m_dt = nd; m_st = ns;
    end
    #1;
    reset = 1'b0; timer_60hz_tick = 1'b0; dt_we = 1'b0; st_we = 1'b0; wdata = 8'd0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      tests_run++;
      if (dut_out() !== 18'h0) begin
        tests_failed++;
        $display("FAIL reset_state: got %h expected %h", dut_out(), 18'h0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      tests_run++;
      if (dut_out() !== 18'h0) begin
        tests_failed++;
        $display("FAIL idle_ticks: got %h expected %h", dut_out(), 18'h0);
      end
    end
  endtask

  task automatic test_decrement();
    logic [7:0] exp_seq [5] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    tests_run++;
    if (dt_value !== 8'd3) begin
      tests_failed++;
      $display("FAIL dt_write: got %0d expected %0d", dt_value, 3);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      tests_run++;
      if (dt_value !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL dt_decrement[%0d]: got %0d expected %0d", i, dt_value, exp_seq[i]);
      end
    end
  endtask

  task automatic test_collision();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h20);
    tests_run++;
    if (dt_value !== 8'h20) begin
      tests_failed++;
      $display("FAIL write_beats_tick: got %h expected %h", dt_value, 8'h20);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'd7);
    tests_run++;
    if ({dt_value, st_value} !== {8'd4, 8'd7}) begin
      tests_failed++;
      $display("FAIL st_write_dt_tick: got dt=%0d st=%0d expected dt=4 st=7", dt_value, st_value);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_sound_duration();
    logic exp_bz;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    tests_run++;
    if ({sound_active, buzzer} !== 2'b10) begin
      tests_failed++;
      $display("FAIL sound_start: got sa=%b bz=%b expected sa=1 bz=0", sound_active, buzzer);
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      exp_bz = ((k / 4) % 2) == 1;
      tests_run++;
      if ({sound_active, buzzer} !== {1'b1, exp_bz}) begin
        tests_failed++;
        $display("FAIL tone_phase[%0d]: got sa=%b bz=%b expected sa=1 bz=%b", k, sound_active, buzzer, exp_bz);
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if ({st_value, sound_active} !== {8'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL first_tick: got st=%0d sa=%b expected st=1 sa=1", st_value, sound_active);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if ({st_value, sound_active, buzzer} !== 10'h0) begin
      tests_failed++;
      $display("FAIL sound_end: got st=%0d sa=%b bz=%b expected all 0", st_value, sound_active, buzzer);
    end
  endtask

  task automatic test_abort_restart();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if (buzzer !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_abort_high: got %b expected 1", buzzer);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    tests_run++;
    if ({sound_active, buzzer} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort: got sa=%b bz=%b expected 00", sound_active, buzzer);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      tests_run++;
      if (buzzer !== 1'(k >= 4)) begin
        tests_failed++;
        $display("FAIL restart_phase[%0d]: got %b expected %b", k, buzzer, 1'(k >= 4));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd9);
    for (int k = 6; k <= 9; k++) begin
      if (k > 6) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      tests_run++;
      if ({st_value, buzzer} !== {8'd9, 1'(((k / 4) % 2) == 1)}) begin
        tests_failed++;
        $display("FAIL rewrite_no_glitch[%0d]: got st=%0d bz=%b expected st=9 bz=%b", k, st_value, buzzer, 1'(((k / 4) % 2) == 1));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  task automatic test_reset_mid_tone();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd50);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if (buzzer !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_tone_high: got %b expected 1", buzzer);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    tests_run++;
    if ({st_value, sound_active, buzzer} !== 10'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_tone: got st=%0d sa=%b bz=%b expected all 0", st_value, sound_active, buzzer);
    end
  endtask

  task automatic test_random();
    logic       r, t, dw, sw;
    logic [7:0] wd;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      t  = ($urandom_range(0, 3) == 0);
      dw = ($urandom_range(0, 7) == 0);
      sw = ($urandom_range(0, 7) == 0);
      wd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      step(r, t, dw, sw, wd);
      tests_run++;
      if (dut_out() !== model_out()) begin
        tests_failed++;
        $display("FAIL random[%0d]: got dt=%0d st=%0d sa=%b bz=%b expected dt=%0d st=%0d sa=%b bz=%b",
                 i, dt_value, st_value, sound_active, buzzer,
                 model_out()[17:10], model_out()[9:2], model_out()[1], model_out()[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decrement();
    test_collision();
    test_sound_duration();
    test_abort_restart();
    test_reset_mid_tone();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
